// File: rtl/actv_relu_pipe_if.sv
// Handshake bundle for actv_relu_pipe: the input beat channel and the output beat channel.
// The unit connects through the slave modport. The producer and consumer side (or a bench) uses master.
interface actv_relu_pipe_if #(
   parameter int WIDTH = 16,
   parameter int LANES = 4
);
   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             in_mode;
   logic [LANES*WIDTH-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*WIDTH-1:0] out_data;

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/actv_relu_pipe.sv
// actv_relu_pipe: LANES-wide, two-stage, valid/ready activation unit.
// Each beat selects one of four modes: pass, ReLU, leaky ReLU (round-half-up and saturate), or clip.
// Stage 1 captures x, mode, the full-width x*coeff products and the ceiling.
// Stage 2 holds the rounded, saturated and selected result that drives out_data.
// Optional feature: define ACTV_CLIP_EN to build the ceiling register and the clip mode.
// Without it, cfg_ceil is ignored and mode 11 behaves as ReLU.
module actv_relu_pipe #(
   parameter int                      WIDTH     = 16,
   parameter int                      FRAC_BITS = 8,
   parameter int                      LANES     = 4,
   parameter logic signed [WIDTH-1:0] COEFF_RST = 16'sh001A,
   parameter logic signed [WIDTH-1:0] CEIL_RST  = 16'sh0600
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic signed [WIDTH-1:0] cfg_coeff,
   input  logic signed [WIDTH-1:0] cfg_ceil,
   actv_relu_pipe_if.slave         bus,
   input  logic                    sat_clr,
   output logic [15:0]             sat_count
);

   localparam int PW = 2 * WIDTH;
   localparam logic signed [PW-1:0] RND_HALF = PW'(1 << (FRAC_BITS - 1));
   localparam logic signed [PW-1:0] SAT_MAX  = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN  = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_RELU  = 2'b01,
      MODE_LEAKY = 2'b10,
      MODE_CLIP  = 2'b11
   } mode_e;

   // Configuration registers
   logic signed [WIDTH-1:0] coeff_q, coeff_d;
`ifdef ACTV_CLIP_EN
   logic signed [WIDTH-1:0] ceil_q, ceil_d;
`else
   logic unused_ceil;
   assign unused_ceil = ^{cfg_ceil, CEIL_RST};
`endif

   // Stage 1
   logic                    s1_valid_q, s1_valid_d;
   mode_e                   s1_mode_q, s1_mode_d;
   logic signed [WIDTH-1:0] s1_x_q    [LANES];
   logic signed [WIDTH-1:0] s1_x_d    [LANES];
   logic signed [PW-1:0]    s1_prod_q [LANES];
   logic signed [PW-1:0]    s1_prod_d [LANES];
`ifdef ACTV_CLIP_EN
   logic signed [WIDTH-1:0] s1_ceil_q, s1_ceil_d;
`endif

   // Stage 2
   logic                    s2_valid_q, s2_valid_d;
   logic signed [WIDTH-1:0] s2_y_q [LANES];
   logic signed [WIDTH-1:0] s2_y_d [LANES];
   logic [15:0]             sat_count_q, sat_count_d;

   // Per-lane results computed from the stage-1 registers
   logic signed [WIDTH-1:0] lane_y   [LANES];
   logic                    lane_sat [LANES];

   logic s1_advance;
   logic s2_load;
   logic in_accept;

   // Handshake: stage 1 moves on whenever stage 2 is empty or being drained this cycle.
   assign s1_advance   = !s2_valid_q || bus.out_ready;
   assign s2_load      = s1_valid_q && s1_advance;
   assign bus.in_ready = !s1_valid_q || s1_advance;
   assign in_accept    = bus.in_valid && bus.in_ready;
   assign bus.out_valid = s2_valid_q;
   assign sat_count     = sat_count_q;

   // Config update. The _d value is also what an accept in the same cycle captures.
   always_comb begin
      coeff_d = cfg_we ? cfg_coeff : coeff_q;
`ifdef ACTV_CLIP_EN
      ceil_d  = cfg_we ? cfg_ceil : ceil_q;
`endif
   end

   // Stage 1: capture the beat, its mode, the products and the ceiling on accept.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      s1_valid_d = s1_valid_q;
      s1_mode_d  = s1_mode_q;
      s1_x_d     = s1_x_q;
      s1_prod_d  = s1_prod_q;
`ifdef ACTV_CLIP_EN
      s1_ceil_d  = s1_ceil_q;
`endif
      if (bus.in_ready) s1_valid_d = in_accept;
      if (in_accept) begin
         s1_mode_d = mode_e'(bus.in_mode);
         for (int i = 0; i < LANES; i++) begin
            s1_x_d[i]    = $signed(bus.in_data[i*WIDTH +: WIDTH]);
            s1_prod_d[i] = PW'(s1_x_d[i]) * PW'(coeff_d);
         end
`ifdef ACTV_CLIP_EN
         s1_ceil_d = ceil_d;
`endif
      end
   end

   // Stage 2: round, saturate and select each lane, then count the clamps at load.
   always_comb begin
      logic signed [PW-1:0]    rnd;
      logic signed [WIDTH-1:0] relu_y;
      logic [16:0]             sat_sum;
      int                      nsat;
      rnd     = '0;
      relu_y  = '0;
      nsat    = 0;
      sat_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         rnd         = (s1_prod_q[i] + RND_HALF) >>> FRAC_BITS;
         relu_y      = s1_x_q[i][WIDTH-1] ? '0 : s1_x_q[i];
         lane_sat[i] = 1'b0;
         lane_y[i]   = s1_x_q[i];
         case (s1_mode_q)
            MODE_PASS: lane_y[i] = s1_x_q[i];
            MODE_RELU: lane_y[i] = relu_y;
            MODE_LEAKY: begin
               if (s1_x_q[i][WIDTH-1]) begin
                  if (rnd > SAT_MAX) begin
                     lane_y[i]   = SAT_MAX[WIDTH-1:0];
                     lane_sat[i] = 1'b1;
                  end else if (rnd < SAT_MIN) begin
                     lane_y[i]   = SAT_MIN[WIDTH-1:0];
                     lane_sat[i] = 1'b1;
                  end else begin
                     lane_y[i]   = rnd[WIDTH-1:0];
                  end
               end
            end
            MODE_CLIP: begin
`ifdef ACTV_CLIP_EN
               lane_y[i] = (relu_y > s1_ceil_q) ? s1_ceil_q : relu_y;
`else
               lane_y[i] = relu_y;
`endif
            end
            default: lane_y[i] = s1_x_q[i];
         endcase
         if (lane_sat[i]) nsat = nsat + 1;
      end

      s2_valid_d = s2_valid_q;
      s2_y_d     = s2_y_q;
      if (s1_advance) s2_valid_d = s1_valid_q;
      if (s2_load) s2_y_d = lane_y;

      sat_count_d = sat_count_q;
      if (sat_clr) begin
         sat_count_d = '0;
      end else if (s2_load) begin
         sat_sum     = {1'b0, sat_count_q} + 17'(nsat);
         sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
   end

   // Output packing in the same lane order as in_data.
   always_comb begin
      bus.out_data = '0;
      for (int i = 0; i < LANES; i++) bus.out_data[i*WIDTH +: WIDTH] = s2_y_q[i];
   end

   // State registers. A reset empties both stages and restores the configuration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the datapath registers are reset as well, so out_data reads zero during and after reset.
         coeff_q     <= COEFF_RST;
`ifdef ACTV_CLIP_EN
         ceil_q      <= CEIL_RST;
         s1_ceil_q   <= CEIL_RST;
`endif
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= MODE_PASS;
         s2_valid_q  <= 1'b0;
         sat_count_q <= '0;
         for (int i = 0; i < LANES; i++) begin
            s1_x_q[i]    <= '0;
            s1_prod_q[i] <= '0;
            s2_y_q[i]    <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
         coeff_q     <= coeff_d;
`ifdef ACTV_CLIP_EN
         ceil_q      <= ceil_d;
         s1_ceil_q   <= s1_ceil_d;
`endif
         s1_valid_q  <= s1_valid_d;
         s1_mode_q   <= s1_mode_d;
         s2_valid_q  <= s2_valid_d;
         sat_count_q <= sat_count_d;
         s1_x_q      <= s1_x_d;
         s1_prod_q   <= s1_prod_d;
         s2_y_q      <= s2_y_d;
      end
   end

endmodule
